inst_fetch_queue: RTL and testbench

// Instruction prefetch queue between instruction memory and the IF_ID register.

---
 rtl/inst_fetch_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Instruction prefetch queue sitting between a 64-word instruction memory and
// the IF_ID register. It issues in-order fetches and tolerates variable memory
// latency. Each returned instruction is buffered with its PC and handed to decode
// over valid/ready. A branch redirect empties the queue and restarts fetching at
// the target. Responses that were already in flight at the redirect are counted
// down and thrown away.
//
// Optional feature macro: IFQ_STATS_EN (adds flush/starve statistics counters).
//
// Ports
//   i_clk, i_clear                 clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr        fetch request and its address (= fetch PC)
//   i_imem_gnt                     memory accepts the request this cycle
//   i_imem_rvalid, i_imem_rdata    in-order fetch response
//   i_redirect, i_redirect_pc      taken branch from MEM: flush and refetch
//   o_out_valid, i_out_ready       head-of-queue handshake towards decode
//   o_out_inst, o_out_pc           head instruction and its address
//   o_stat_flush_cnt               redirect count (IFQ_STATS_EN only)
//   o_stat_starve_cnt              starved RUN cycles (IFQ_STATS_EN only)

// Simulation-only check: a response must always match an outstanding fetch.
module inst_fetch_queue_chk #(
  parameter int CW = 3
) (
  input logic          i_clk,
  input logic          i_clear,
  input logic          i_rvalid,
  input logic [CW-1:0] i_outstanding
);
  // Flag a response that arrives with no fetch outstanding
  always @(posedge i_clk) begin
    if (i_clear && i_rvalid) begin
      assert (i_outstanding != {CW{1'b0}})
        else $error("inst_fetch_queue: response with no fetch outstanding");
    end
  end
endmodule

module inst_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int AW       = 6,
  parameter int IW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic          i_clk,
  input  logic          i_clear,
  output logic          o_imem_req,
  output logic [AW-1:0] o_imem_addr,
  input  logic          i_imem_gnt,
  input  logic          i_imem_rvalid,
  input  logic [IW-1:0] i_imem_rdata,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [IW-1:0] o_out_inst,
  output logic [AW-1:0] o_out_pc
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]   o_stat_flush_cnt,
  output logic [15:0]   o_stat_starve_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] RST_PC   = AW'(RESET_PC);
  localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_fetch_pc, r_resp_pc;
  logic [CW-1:0] r_count, r_outstanding, r_discard;
  logic [CW-1:0] w_count_nxt, w_outstanding_nxt, w_discard_nxt;
  logic [PW-1:0] r_head, r_tail;
  logic [IW-1:0] r_inst [DEPTH];
  logic [AW-1:0] r_pc   [DEPTH];
  logic [CW:0]   w_credit;
  logic          w_req, w_grant, w_resp, w_push, w_pop;

  // Request credit, handshakes and queue/in-flight counter updates
  always_comb begin
    // Queued plus in-flight never exceeds DEPTH, so a response always finds room.
    w_credit          = {1'b0, r_count} + {1'b0, r_outstanding};
    w_req             = (r_state == S_RUN) && !i_redirect && (w_credit < DEPTH_C);
    w_grant           = w_req && i_imem_gnt;
    w_resp            = i_imem_rvalid && (r_outstanding != CNT_ZERO);
    w_outstanding_nxt = r_outstanding + {{(CW-1){1'b0}}, w_grant}
                                      - {{(CW-1){1'b0}}, w_resp};
    w_push            = w_resp && (r_state == S_RUN) && !i_redirect;
    w_pop             = (r_count != CNT_ZERO) && i_out_ready && !i_redirect;
    if (i_redirect) begin
      w_count_nxt = CNT_ZERO;
    end else begin
      w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  // Next-state and discard-count logic; redirect overrides every state
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    if (i_redirect) begin
      // Every fetch still in flight after this cycle belongs to the old path.
      w_discard_nxt = w_outstanding_nxt;
      if (w_outstanding_nxt != CNT_ZERO) begin
        w_state_nxt = S_FLUSH;
      end else begin
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        S_FLUSH: begin
          if (w_resp) begin
            w_discard_nxt = r_discard - CNT_ONE;
          end else begin
            w_discard_nxt = r_discard;
          end
          if (w_discard_nxt == CNT_ZERO) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_discard_nxt = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PCs, counters and queue storage
  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_fetch_pc    <= RST_PC;
      r_resp_pc     <= RST_PC;
      r_count       <= CNT_ZERO;
      r_outstanding <= CNT_ZERO;
      r_discard     <= CNT_ZERO;
      r_head        <= PTR_ZERO;
      r_tail        <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= {IW{1'b0}};
        r_pc[i]   <= {AW{1'b0}};
      end
    end else begin
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
      if (i_redirect) begin
        r_fetch_pc <= i_redirect_pc;
        r_resp_pc  <= i_redirect_pc;
        r_head     <= PTR_ZERO;
        r_tail     <= PTR_ZERO;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + PC_ONE;
        end
        if (w_push) begin
          r_inst[r_tail] <= i_imem_rdata;
          r_pc[r_tail]   <= r_resp_pc;
          r_tail         <= r_tail + PTR_ONE;
          r_resp_pc      <= r_resp_pc + PC_ONE;
        end
        if (w_pop) begin
          r_head <= r_head + PTR_ONE;
        end
      end
    end
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fetch_pc;
  assign o_out_valid = (r_count != CNT_ZERO);
  assign o_out_inst  = r_inst[r_head];
  assign o_out_pc    = r_pc[r_head];

`ifdef IFQ_STATS_EN
  logic [15:0] r_flush_cnt, r_starve_cnt;

  // Saturating redirect and decode-starvation counters
  always_ff @(posedge i_clk or negedge i_clear) begin
    if (!i_clear) begin
      r_flush_cnt  <= 16'h0000;
      r_starve_cnt <= 16'h0000;
    end else begin
      if (i_redirect && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'h0001;
      end
      if ((r_state == S_RUN) && i_out_ready && (r_count == CNT_ZERO) &&
          (r_starve_cnt != 16'hFFFF)) begin
        r_starve_cnt <= r_starve_cnt + 16'h0001;
      end
    end
  end

  assign o_stat_flush_cnt  = r_flush_cnt;
  assign o_stat_starve_cnt = r_starve_cnt;
`endif

  inst_fetch_queue_chk #(.CW(CW)) u_chk (
    .i_clk         (i_clk),
    .i_clear       (i_clear),
    .i_rvalid      (i_imem_rvalid),
    .i_outstanding (r_outstanding)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-based reference model is
// stepped once per clock and compared against the DUT outputs every cycle.
// Directed scenarios pin the model with hand-computed values, then a long
// randomized phase exercises grants, latencies, backpressure, redirects and clears.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect = 1'b0;
  logic [5:0]  redirect_pc = 6'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_inst;
  logic [5:0]  out_pc;
`ifdef IFQ_STATS_EN
  logic [15:0] stat_flush_cnt, stat_starve_cnt;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(6), .IW(16), .RESET_PC(0)) dut (
    .i_clk         (clk),
    .i_clear       (clear),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_inst    (out_inst),
    .o_out_pc      (out_pc)
`ifdef IFQ_STATS_EN
    ,
    .o_stat_flush_cnt  (stat_flush_cnt),
    .o_stat_starve_cnt (stat_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] inst; logic [5:0] pc; } ent_t;
  typedef struct { logic [5:0] addr; int due; } pend_t;

  // Reference model state
  ent_t       m_q[$];
  bit         m_started;
  int         m_out, m_discard, m_flush, m_starve;
  logic [5:0] m_fetch, m_resp;

  // Memory responder and observation lists
  pend_t      pend[$];
  logic [5:0] g_addrs[$];
  logic [5:0] dpcs[$];

  int checks = 0, errors = 0, cyc = 0, rv_cnt = 0;
  int p_gnt = 100, p_ready = 0, lat_min = 1, lat_max = 1;
  bit clr_val = 1'b0, redir_req = 1'b0;
  logic [5:0] redir_tgt = 6'd0;
  logic d_req, d_valid;
  logic [5:0] d_addr, d_pc;
  logic [15:0] d_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [5:0] a);
    return 16'h1000 + {10'd0, a};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_started = 1'b0;
    m_out = 0;
    m_discard = 0;
    m_fetch = 6'd0;
    m_resp = 6'd0;
    m_flush = 0;
    m_starve = 0;
  endtask

  // One clock: drive inputs at negedge, compare outputs, advance the model.
  task automatic tick();
    bit    run, exp_req;
    int    grant, resp;
    bit    pop;
    pend_t p;
    ent_t  e;
    @(negedge clk);
    clear       = clr_val;
    imem_gnt    = ($urandom_range(99) < p_gnt);
    out_ready   = ($urandom_range(99) < p_ready);
    redirect    = redir_req && clr_val;
    redirect_pc = redir_tgt;
    redir_req   = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    if (!clear) model_reset();
    #1;
    d_req = imem_req; d_addr = imem_addr; d_valid = out_valid;
    d_inst = out_inst; d_pc = out_pc;
    run     = m_started && (m_discard == 0);
    exp_req = run && !redirect && (m_q.size() + m_out < DEPTH);
    chk("imem_req", d_req, exp_req);
    chk("imem_addr", d_addr, m_fetch);
    chk("out_valid", d_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_inst", d_inst, m_q[0].inst);
      chk("out_pc", d_pc, m_q[0].pc);
    end
`ifdef IFQ_STATS_EN
    chk("stat_flush", stat_flush_cnt, m_flush);
    chk("stat_starve", stat_starve_cnt, m_starve);
`endif
    if (imem_rvalid) begin
      void'(pend.pop_front());
      rv_cnt++;
    end
    if (!clear) begin
      pend.delete();
    end else begin
      grant = (exp_req && imem_gnt) ? 1 : 0;
      resp  = (imem_rvalid && m_out > 0) ? 1 : 0;
      pop   = (m_q.size() != 0) && out_ready && !redirect;
      if (pop) dpcs.push_back(d_pc);
      if (redirect && m_flush < 65535) m_flush++;
      if (run && out_ready && m_q.size() == 0 && m_starve < 65535) m_starve++;
      if (grant != 0) begin
        p.addr = m_fetch;
        p.due  = cyc + lat_min + int'($urandom_range(lat_max - lat_min));
        pend.push_back(p);
        g_addrs.push_back(m_fetch);
      end
      m_out = m_out + grant - resp;
      if (redirect) begin
        m_q.delete();
        m_discard = m_out;
        m_fetch = redirect_pc;
        m_resp = redirect_pc;
      end else begin
        if (grant != 0) m_fetch++;
        if (pop) void'(m_q.pop_front());
        if (resp != 0) begin
          if (m_discard > 0) begin
            m_discard--;
          end else begin
            e.inst = imem_rdata;
            e.pc   = m_resp;
            m_q.push_back(e);
            m_resp++;
          end
        end
      end
      m_started = 1'b1;
    end
    cyc++;
  endtask

  task automatic do_reset();
    clr_val = 1'b0;
    redir_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", d_req, 0);
      chk("rst_valid", d_valid, 0);
      chk("rst_addr", d_addr, 0);
      chk("rst_inst", d_inst, 0);
      chk("rst_pc", d_pc, 0);
    end
    clr_val = 1'b1;
    tick();
  endtask

  initial begin
    logic [5:0] wexp [4];
    wexp[0] = 6'd62; wexp[1] = 6'd63; wexp[2] = 6'd0; wexp[3] = 6'd1;
    #1 clear = 1'b0;

`ifdef IFQ_STATS_EN
    // Statistics: 5 starved RUN cycles then 2 redirects
    p_gnt = 0; p_ready = 0;
    do_reset();
    p_ready = 100;
    repeat (5) tick();
    p_ready = 0;
    redir_req = 1'b1; redir_tgt = 6'd5; tick();
    redir_req = 1'b1; redir_tgt = 6'd9; tick();
    tick();
    chk("stats_flush_lit", stat_flush_cnt, 16'd2);
    chk("stats_starve_lit", stat_starve_cnt, 16'd5);
`endif

    // Reset then stream at 1-cycle latency
    p_gnt = 100; p_ready = 100; lat_min = 1; lat_max = 1;
    do_reset();
    tick();
    chk("stream_first_req", d_req, 1);
    chk("stream_first_addr", d_addr, 0);
    tick();
    tick();
    chk("stream_valid0", d_valid, 1);
    chk("stream_inst0", d_inst, 16'h1000);
    chk("stream_pc0", d_pc, 0);
    tick();
    chk("stream_inst1", d_inst, 16'h1001);
    chk("stream_pc1", d_pc, 1);

    // Backpressure: exactly DEPTH grants, then drain in order
    p_ready = 0;
    do_reset();
    g_addrs.delete();
    dpcs.delete();
    repeat (10) tick();
    chk("bp_grants", g_addrs.size(), 4);
    chk("bp_req_off", d_req, 0);
    p_ready = 100;
    for (int i = 0; i < 40 && dpcs.size() < 8; i++) tick();
    for (int i = 0; i < 8; i++) begin
      chk("bp_order", (i < dpcs.size()) ? dpcs[i] : 6'h3f, i);
    end

    // Redirect with two fetches in flight
    p_ready = 0; lat_min = 2; lat_max = 2;
    do_reset();
    repeat (4) tick();
    chk("redir_pre_valid", d_valid, 1);
    rv_cnt = 0;
    redir_req = 1'b1; redir_tgt = 6'd20;
    tick();
    tick();
    chk("redir_valid_gone", d_valid, 0);
    for (int i = 0; i < 20 && !d_req; i++) tick();
    chk("redir_req_seen", d_req, 1);
    chk("redir_dropped", rv_cnt, 2);
    chk("redir_addr", d_addr, 20);
    p_ready = 100; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && !d_valid; i++) tick();
    chk("redir_out_valid", d_valid, 1);
    chk("redir_out_pc", d_pc, 20);
    chk("redir_out_inst", d_inst, 16'h1014);

    // PC wrap
    redir_req = 1'b1; redir_tgt = 6'd62;
    tick();
    g_addrs.delete();
    dpcs.delete();
    repeat (15) tick();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_grant_addr", (i < g_addrs.size()) ? g_addrs[i] : 6'h2a, wexp[i]);
      chk("wrap_out_pc", (i < dpcs.size()) ? dpcs[i] : 6'h2a, wexp[i]);
    end

    // Mid-run clear with 3 queued and 1 in flight
    p_ready = 0;
    do_reset();
    repeat (4) tick();
    chk("clr_model_q", m_q.size(), 3);
    chk("clr_model_out", m_out, 1);
    clr_val = 1'b0;
    rv_cnt = 0;
    tick();
    chk("clr_valid", d_valid, 0);
    chk("clr_req", d_req, 0);
    chk("clr_late_rvalid", rv_cnt, 1);
    tick();
    clr_val = 1'b1;
    tick();
    tick();
    chk("clr_refetch_req", d_req, 1);
    chk("clr_refetch_addr", d_addr, 0);
    p_ready = 100;
    for (int i = 0; i < 20 && !d_valid; i++) tick();
    chk("clr_first_pc", d_pc, 0);
    chk("clr_first_inst", d_inst, 16'h1000);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        p_gnt   = int'($urandom_range(100, 20));
        p_ready = int'($urandom_range(100, 0));
        lat_min = int'($urandom_range(3, 1));
        lat_max = lat_min + int'($urandom_range(4, 0));
      end
      if (!clr_val) begin
        clr_val = 1'b1;
      end else if ($urandom_range(399) == 0) begin
        clr_val = 1'b0;
      end else if ($urandom_range(24) == 0) begin
        redir_req = 1'b1;
        redir_tgt = 6'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
